blk_cda3da: RTL and testbench
=============================

# integrated_module1_nios2_qsys_0_oci_dct_sequencer

Packs 2-bit data-trace (DCT) symbols from the Nios II OCI into 30-bit trace frames, counts them, and hands complete or flushed frames downstream over a valid/ready handshake. It sequences the `dct_buffer`/`dct_count` datapath consumed by the OCI test bench and owns the end-of-test handshake. On `test_ending` it drains all pending trace, then asserts `test_has_ended`.

## Interface
- `SYM_W`, 2: trace symbol width.
- `DEPTH`, 15: symbols per frame; frame width `SYM_W*DEPTH` = 30.
- `CNT_W`, 4: width of `dct_count`; must satisfy 2^CNT_W > DEPTH.
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `trace_en` in 1: when low, `sym_valid` is ignored (no overflow).
- `sym_valid` in 1: one trace symbol offered this cycle.
- `sym` in SYM_W: symbol code.
- `flush` in 1: single-cycle pulse; emit the partial frame.
- `test_ending` in 1: request end of test; level or pulse, latched.
- `dct_buffer` out 30: frame data; newest symbol in bits [1:0].
- `dct_count` out CNT_W: valid symbols in `dct_buffer` (1..15).
- `frame_valid` out 1: frame presented.
- `frame_ready` in 1: downstream accepts when high with `frame_valid`.
- `overflow` out 1: sticky; a symbol was dropped.
- `test_has_ended` out 1: sticky; all trace drained after `test_ending`.

## Operation
- Fill register `fbuf`/`fcnt`. An accepted symbol gives `fbuf_n = {fbuf[27:0], sym}` and `fcnt_n = fcnt+1`.
- A symbol is accepted when `trace_en && sym_valid && state==RUN && fcnt<15`.
- `sym_valid` while `fcnt==15` and no transfer this cycle: the symbol is dropped and `overflow` is set.
- Output slot is free when `!frame_valid || frame_ready`.
- Transfer happens when the slot is free and any of these holds:
  - `fcnt_n==15`;
  - (`flush_pend` or `flush`) and `fcnt_n!=0`;
  - `state==ENDING` and `fcnt_n!=0`.
- On transfer:
  - `dct_buffer<=fbuf_n`, `dct_count<=fcnt_n`, `frame_valid<=1`;
  - `fbuf<=0`, `fcnt<=0`, `flush_pend<=0`.
- Unused MSBs of a partial frame are zero.
- If no transfer occurs and the slot is free with `frame_ready`: `frame_valid<=0`.
- `flush` while the slot is busy latches `flush_pend`.
- `flush` with an empty fill register and no same-cycle symbol is a no-op; `flush_pend` is not set.
- A symbol accepted in the same cycle as `flush` is included in the flushed frame.
- States:
  - RUN: normal operation.
  - ENDING: entered on `test_ending`. New symbols are ignored (not counted as overflow) and partial data is forced out.
  - ENDED: entered from ENDING when `fcnt==0 && !frame_valid`. Sets `test_has_ended`. Terminal until reset.
- `test_ending` while `fcnt==0 && !frame_valid`: RUN→ENDING→ENDED takes two edges.
- `flush` and `trace_en` have no effect in ENDED.

## Timing
- Reset values: `dct_buffer=0`, `dct_count=0`, `frame_valid=0`, `overflow=0`, `test_has_ended=0`. Internally `fbuf=0`, `fcnt=0`, `flush_pend=0`, state RUN.
- Reset mid-frame discards all buffered trace with no output.
- Latency: a symbol completing a frame at edge N with the slot free gives `frame_valid=1` from edge N.
- A frame completed while the slot is busy holds at `fcnt==15`. It transfers on the first edge where `frame_ready` is sampled high, so back-to-back frames are possible.
- While `frame_valid && !frame_ready`, `dct_buffer` and `dct_count` are stable.
- Maximum sustained throughput: 1 symbol/cycle with `frame_ready` held high.
- `test_has_ended` rises exactly one edge after the last frame handshake, or after entry to ENDING if nothing is pending.

## Structure
- Package `nios2_oci_dct_pkg`: `SYM_W`, `DEPTH`, `CNT_W`, frame-width constant, and the state encoding RUN=2'd0, ENDING=2'd1, ENDED=2'd2.
- One sub-module: `nios2_oci_dct_frame_reg`, the output valid/ready holding register (load, hold, clear).
- Packing and FSM stay in the top.

## Test plan
- Reset, then 15 symbols `sym=2'b01` back-to-back with `frame_ready=1`: one frame, `dct_buffer=30'h15555555`, `dct_count=15`, `frame_valid` for exactly 1 cycle.
- 5 symbols `2'b11`, then `flush`: `dct_count=5`, `dct_buffer=30'h3FF`. A second `flush` with an empty buffer produces no frame.
- `frame_ready=0` and 31 symbols: first frame held stable; second fill stops at 15; 31st symbol dropped and `overflow=1`. Raise `frame_ready`: frames go out in order; `overflow` stays 1.
- 7 symbols, then `test_ending` with `frame_ready=0` for 3 cycles, then 1: a 7-symbol frame is presented; `test_has_ended` rises one edge after the handshake; later symbols are ignored.
- Symbol 15 arrives in the same cycle as `flush`: a single 15-symbol frame is produced, not a 14 then a 1.
- Assert `reset_n` low asynchronously mid-frame with `frame_valid=1`: all outputs are 0 immediately; the next 15 symbols produce a clean frame.

Source files
------------

// File: rtl/nios2_oci_dct_pkg.sv
// Shared constants for the OCI data-trace sequencer: symbol/frame geometry,
// sequencer state encoding and the symbol-packing helper.
package nios2_oci_dct_pkg;

    localparam int SYM_W   = 2;
    localparam int DEPTH   = 15;
    localparam int CNT_W   = 4;
    localparam int FRAME_W = SYM_W * DEPTH;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_CNT = 4'd0;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_ENDING = 2'd1;
    localparam logic [1:0] ST_ENDED  = 2'd2;

    // Newest symbol always lands in the low bits of the frame.
    function automatic logic [FRAME_W-1:0] push_sym(
        input logic [FRAME_W-1:0] frame,
        input logic [SYM_W-1:0]   s
    );
        return {frame[FRAME_W-SYM_W-1:0], s};
    endfunction

endpackage

// File: rtl/nios2_oci_dct_frame_reg.sv
// Output holding register for trace frames: loads a new frame, holds it while
// downstream stalls, and drops frame_valid once the frame has been taken.
module nios2_oci_dct_frame_reg
    import nios2_oci_dct_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_frame,
    input  logic [CNT_W-1:0]   load_count,
    input  logic               frame_ready,
    output logic [FRAME_W-1:0] frame,
    output logic [CNT_W-1:0]   count,
    output logic               frame_valid
);

    logic [FRAME_W-1:0] frame_r;
    logic [CNT_W-1:0]   count_r;
    logic               valid_r;

    // Load has priority; otherwise a sampled ready retires the presented frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_r <= {FRAME_W{1'b0}};
            count_r <= ZERO_CNT;
            valid_r <= 1'b0;
        end else if (load) begin
            frame_r <= load_frame;
            count_r <= load_count;
            valid_r <= 1'b1;
        end else if (frame_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign frame       = frame_r;
    assign count       = count_r;
    assign frame_valid = valid_r;

endmodule

// File: rtl/blk_cda3da.sv
// Nios II OCI data-trace sequencer: packs 2-bit trace symbols into 15-symbol
// frames, hands them downstream over valid/ready, and drains on end of test.
module blk_cda3da
    import nios2_oci_dct_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               trace_en,
    input  logic               sym_valid,
    input  logic [SYM_W-1:0]   sym,
    input  logic               flush,
    input  logic               test_ending,
    output logic [FRAME_W-1:0] dct_buffer,
    output logic [CNT_W-1:0]   dct_count,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic               overflow,
    output logic               test_has_ended
);

    logic [FRAME_W-1:0] fbuf_r;
    logic [CNT_W-1:0]   fcnt_r;
    logic               flush_pend_r;
    logic [1:0]         state_r;
    logic               overflow_r;
    logic               ended_r;

    logic [FRAME_W-1:0] fbuf_n_s;
    logic [CNT_W-1:0]   fcnt_n_s;
    logic               accept_s;
    logic               slot_free_s;
    logic               has_data_s;
    logic               xfer_s;
    logic               drop_s;
    logic               flush_set_s;
    logic [1:0]         state_nx_s;

    // Fill-path next state, transfer decision and sequencer next state.
    always_comb begin
        accept_s    = 1'b0;
        fbuf_n_s    = fbuf_r;
        fcnt_n_s    = fcnt_r;
        slot_free_s = 1'b0;
        has_data_s  = 1'b0;
        xfer_s      = 1'b0;
        drop_s      = 1'b0;
        flush_set_s = 1'b0;
        state_nx_s  = state_r;

        if (trace_en && sym_valid && (state_r == ST_RUN) && (fcnt_r < FULL_CNT)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end

        if (accept_s) begin
            fbuf_n_s = push_sym(fbuf_r, sym);
            fcnt_n_s = fcnt_r + 4'd1;
        end else begin
            fbuf_n_s = fbuf_r;
            fcnt_n_s = fcnt_r;
        end

        slot_free_s = !frame_valid || frame_ready;
        has_data_s  = (fcnt_n_s != ZERO_CNT);

        if (slot_free_s && ((fcnt_n_s == FULL_CNT) ||
                            ((flush_pend_r || flush) && has_data_s && (state_r != ST_ENDED)) ||
                            ((state_r == ST_ENDING) && has_data_s))) begin
            xfer_s = 1'b1;
        end else begin
            xfer_s = 1'b0;
        end

        // A symbol offered against a full, stalled fill register is lost.
        if (trace_en && sym_valid && (state_r == ST_RUN) && (fcnt_r == FULL_CNT) && !xfer_s) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end

        if (flush && (state_r != ST_ENDED) && has_data_s && !xfer_s) begin
            flush_set_s = 1'b1;
        end else begin
            flush_set_s = 1'b0;
        end

        case (state_r)
            ST_RUN: begin
                if (test_ending) begin
                    state_nx_s = ST_ENDING;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_ENDING: begin
                if ((fcnt_r == ZERO_CNT) && !frame_valid) begin
                    state_nx_s = ST_ENDED;
                end else begin
                    state_nx_s = ST_ENDING;
                end
            end
            ST_ENDED: state_nx_s = ST_ENDED;
            default:  state_nx_s = ST_RUN;
        endcase
    end

    // Fill register, pending flush, sequencer state and sticky status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fbuf_r       <= {FRAME_W{1'b0}};
            fcnt_r       <= ZERO_CNT;
            flush_pend_r <= 1'b0;
            state_r      <= ST_RUN;
            overflow_r   <= 1'b0;
            ended_r      <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (xfer_s) begin
                fbuf_r       <= {FRAME_W{1'b0}};
                fcnt_r       <= ZERO_CNT;
                flush_pend_r <= 1'b0;
            end else begin
                fbuf_r       <= fbuf_n_s;
                fcnt_r       <= fcnt_n_s;
                flush_pend_r <= flush_pend_r || flush_set_s;
            end
            overflow_r <= overflow_r || drop_s;
            ended_r    <= ended_r || (state_nx_s == ST_ENDED);
        end
    end

    nios2_oci_dct_frame_reg u_frame_reg (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (xfer_s),
        .load_frame  (fbuf_n_s),
        .load_count  (fcnt_n_s),
        .frame_ready (frame_ready),
        .frame       (dct_buffer),
        .count       (dct_count),
        .frame_valid (frame_valid)
    );

    assign overflow       = overflow_r;
    assign test_has_ended = ended_r;

endmodule

// File: tb/tb_blk_cda3da.sv
// Self-checking bench for blk_cda3da: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the trace sequencer.
module tb_blk_cda3da;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        trace_en = 1'b0;
    logic        sym_valid = 1'b0;
    logic [1:0]  sym = 2'd0;
    logic        flush = 1'b0;
    logic        test_ending = 1'b0;
    logic        frame_ready = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        frame_valid;
    logic        overflow;
    logic        test_has_ended;

    int n_vec = 0;
    int n_err = 0;

    // Model: pending symbols in arrival order, presented frame, flags, mode 0/1/2 = run/ending/ended
    int          fill_q[$];
    bit          m_valid, m_fpend, m_ovf, m_ended;
    logic [29:0] m_buf;
    int          m_cnt;
    int          m_mode;

    blk_cda3da dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .trace_en       (trace_en),
        .sym_valid      (sym_valid),
        .sym            (sym),
        .flush          (flush),
        .test_ending    (test_ending),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .overflow       (overflow),
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fill_q.delete();
        m_valid = 1'b0;
        m_fpend = 1'b0;
        m_ovf   = 1'b0;
        m_ended = 1'b0;
        m_buf   = 30'd0;
        m_cnt   = 0;
        m_mode  = 0;
    endtask

    task automatic model_step();
        int     pre_n, n;
        bit     pre_valid, busy, xf;
        longint acc;
        pre_n     = fill_q.size();
        pre_valid = m_valid;
        busy      = m_valid && !frame_ready;
        if (trace_en && sym_valid && m_mode == 0 && pre_n < 15)
            fill_q.push_back(int'(sym));
        n  = fill_q.size();
        xf = !busy && (n == 15 || ((m_fpend || flush) && n > 0 && m_mode != 2) || (m_mode == 1 && n > 0));
        if (trace_en && sym_valid && m_mode == 0 && pre_n == 15 && !xf)
            m_ovf = 1'b1;
        if (xf) begin
            acc = 0;
            foreach (fill_q[i]) acc = acc * 4 + fill_q[i];
            m_buf   = acc[29:0];
            m_cnt   = n;
            m_valid = 1'b1;
            m_fpend = 1'b0;
            fill_q.delete();
        end else begin
            if (flush && m_mode != 2 && n > 0) m_fpend = 1'b1;
            if (frame_ready) m_valid = 1'b0;
        end
        if (m_mode == 0 && test_ending) begin
            m_mode = 1;
        end else if (m_mode == 1 && pre_n == 0 && !pre_valid) begin
            m_mode  = 2;
            m_ended = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("frame_valid", 32'(frame_valid), 32'(m_valid));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("test_has_ended", 32'(test_has_ended), 32'(m_ended));
        if (m_valid) begin
            chk("dct_buffer", 32'(dct_buffer), 32'(m_buf));
            chk("dct_count", 32'(dct_count), 32'(m_cnt));
        end
    endtask

    task automatic step(input logic sv, input logic [1:0] s, input logic fl, input logic rdy);
        trace_en    = 1'b1;
        sym_valid   = sv;
        sym         = s;
        flush       = fl;
        frame_ready = rdy;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_buf"}, 32'(dct_buffer), 32'd0);
        chk({tag, "_cnt"}, 32'(dct_count), 32'd0);
        chk({tag, "_fv"}, 32'(frame_valid), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_end"}, 32'(test_has_ended), 32'd0);
    endtask

    initial begin
        int          fv_cnt;
        logic [29:0] held;
        model_reset();
        #12;
        chk_all_zero("reset");
        #10 reset_n = 1'b1;

        // Full frame at full rate
        fv_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            step(i < 15, 2'b01, 1'b0, 1'b1);
            if (frame_valid) fv_cnt++;
            if (i == 14) begin
                chk("t1_buf", 32'(dct_buffer), 32'h15555555);
                chk("t1_cnt", 32'(dct_count), 32'd15);
            end
        end
        chk("t1_frames", 32'(fv_cnt), 32'd1);

        // Partial frame via flush, then a flush on an empty buffer
        for (int i = 0; i < 5; i++) step(1'b1, 2'b11, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b1, 1'b1);
        chk("t2_buf", 32'(dct_buffer), 32'h3FF);
        chk("t2_cnt", 32'(dct_count), 32'd5);
        step(1'b0, 2'b00, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b1, 1'b1);
        chk("t2_noframe", 32'(frame_valid), 32'd0);
        step(1'b0, 2'b00, 1'b0, 1'b1);
        chk("t2_noframe2", 32'(frame_valid), 32'd0);

        // Back-pressure: 31 symbols against a stalled sink
        held = 30'd0;
        for (int i = 0; i < 31; i++) begin
            step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
            if (i == 14) held = m_buf;
        end
        chk("t3_hold_buf", 32'(dct_buffer), 32'(held));
        chk("t3_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 1'b0, 1'b1);
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);

        // Fifteenth symbol coincides with flush: one full frame only
        for (int i = 0; i < 14; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b1);
        step(1'b1, 2'b10, 1'b1, 1'b1);
        chk("t5_cnt", 32'(dct_count), 32'd15);
        step(1'b0, 2'b00, 1'b0, 1'b1);
        chk("t5_single", 32'(frame_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            trace_en    = ($urandom_range(0, 7) != 0);
            sym_valid   = ($urandom_range(0, 3) != 0);
            sym         = 2'($urandom_range(0, 3));
            flush       = ($urandom_range(0, 15) == 0);
            frame_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        // Drain and end of test
        step(1'b0, 2'b00, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b1);
        test_ending = 1'b1;
        step(1'b0, 2'b00, 1'b0, 1'b0);
        test_ending = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 2'b11, 1'b0, 1'b0);
        chk("t4_cnt", 32'(dct_count), 32'd7);
        chk("t4_fv", 32'(frame_valid), 32'd1);
        step(1'b1, 2'b11, 1'b0, 1'b1);
        chk("t4_not_yet", 32'(test_has_ended), 32'd0);
        step(1'b1, 2'b11, 1'b0, 1'b1);
        chk("t4_ended", 32'(test_has_ended), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 1'b1, 1'b1);

        // Asynchronous reset mid-frame with a frame presented
        reset_n = 1'b0;
        #20;
        model_reset();
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
        chk("t6_pre_fv", 32'(frame_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk_all_zero("t6_async");
        #3 reset_n = 1'b1;
        for (int i = 0; i < 15; i++) step(1'b1, 2'b10, 1'b0, 1'b1);
        chk("t6_clean_buf", 32'(dct_buffer), 32'h2AAAAAAA);
        chk("t6_clean_cnt", 32'(dct_count), 32'd15);
        step(1'b0, 2'b00, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
